// File: rtl/common_bypass_fifo_active.sv
// DEPTH-entry FIFO between pipeline stages with same-cycle bypass when empty,
// optional registered upstream ready, synchronous flush and occupancy output.
module common_bypass_fifo_active #(
    parameter int BUFFER_WIDTH     = 1,
    parameter int DEPTH            = 2,
    parameter bit READY_REGISTERED = 1'b1,
    localparam int CW              = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [BUFFER_WIDTH-1:0] prev_i_data,
    input  logic                    prev_i_valid,
    output logic                    prev_o_ready,
    output logic [BUFFER_WIDTH-1:0] next_o_data,
    output logic                    next_o_valid,
    input  logic                    next_i_ready,
    output logic [CW-1:0]           o_count
);

    // A single-entry buffer still needs a 1-bit pointer.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BUFFER_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;
    logic                    empty;
    logic                    acc;
    logic                    pop;
    logic                    store;
    logic                    drain;

    assign empty = (count == '0);
    assign acc   = prev_i_valid & prev_o_ready;
    assign pop   = next_o_valid & next_i_ready;

    // A beat taken while empty and downstream ready bypasses storage entirely.
    assign store = acc & ~(empty & next_i_ready);
    assign drain = ~empty & pop;

    assign next_o_valid = ~flush & (~empty | acc);
    assign next_o_data  = empty ? prev_i_data : mem[rd_ptr];
    assign o_count      = count;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({store, drain})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (store) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                if (drain) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: storage is deliberately not reset; count gates its visibility, and no reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= prev_i_data;
    end

    generate
        if (READY_REGISTERED) begin : g_ready_reg
            logic ready_q;
            logic ready_q_d;

            // Ready tracks next-cycle occupancy, so an accepted beat always has a slot.
            assign ready_q_d = flush ? 1'b1 : (count_next < CW'(DEPTH));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) ready_q <= 1'b0;
                else       ready_q <= ready_q_d;
            end

            assign prev_o_ready = ready_q & ~flush;
        end else begin : g_ready_comb
            assign prev_o_ready = ~flush & ((count < CW'(DEPTH)) | next_i_ready);
        end
    endgenerate

endmodule

// File: tb/tb_common_bypass_fifo_active.sv
// Drives three FIFO configurations with shared stimulus and checks each against
// a queue-based reference model derived from the buffer's transfer rules.
module tb_common_bypass_fifo_active;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [7:0] prev_i_data;
    logic       prev_i_valid;
    logic       next_i_ready;

    logic       a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
    logic [7:0] a_data, b_data, c_data;
    logic [1:0] a_count;
    logic [2:0] b_count;
    logic [1:0] c_count;

    int n_checks = 0;
    int n_errors = 0;

    byte_q_t q_a, q_b, q_c;
    bit      rdy_a, rdy_b, rdy_c;
    bit      acc_a, acc_b, acc_c;

    always #5 clk = ~clk;

    common_bypass_fifo_active #(.BUFFER_WIDTH(8), .DEPTH(2), .READY_REGISTERED(1'b1)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .prev_i_data(prev_i_data), .prev_i_valid(prev_i_valid), .prev_o_ready(a_ready),
        .next_o_data(a_data), .next_o_valid(a_valid), .next_i_ready(next_i_ready),
        .o_count(a_count)
    );

    common_bypass_fifo_active #(.BUFFER_WIDTH(8), .DEPTH(4), .READY_REGISTERED(1'b1)) u_b (
        .clk(clk), .reset(reset), .flush(flush),
        .prev_i_data(prev_i_data), .prev_i_valid(prev_i_valid), .prev_o_ready(b_ready),
        .next_o_data(b_data), .next_o_valid(b_valid), .next_i_ready(next_i_ready),
        .o_count(b_count)
    );

    common_bypass_fifo_active #(.BUFFER_WIDTH(8), .DEPTH(3), .READY_REGISTERED(1'b0)) u_c (
        .clk(clk), .reset(reset), .flush(flush),
        .prev_i_data(prev_i_data), .prev_i_valid(prev_i_valid), .prev_o_ready(c_ready),
        .next_o_data(c_data), .next_o_valid(c_valid), .next_i_ready(next_i_ready),
        .o_count(c_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    // Reference: the stored entries are a queue; a beat bypasses only when the
    // queue is empty and downstream takes it in the same cycle.
    task automatic model_step(input string tag, input int depth, input bit regm,
                              inout byte_q_t q, inout bit rdy,
                              input logic ready, input logic valid,
                              input logic [7:0] data, input logic [2:0] count,
                              output bit acc);
        int sz;
        bit e_ready, e_valid, pop;
        sz      = q.size();
        e_ready = flush ? 1'b0 : (regm ? rdy : ((sz < depth) || next_i_ready));
        e_valid = !flush && ((sz != 0) || (prev_i_valid && e_ready));
        check({tag, " ready"}, 32'(ready), 32'(e_ready));
        check({tag, " valid"}, 32'(valid), 32'(e_valid));
        check({tag, " count"}, 32'(count), 32'(sz));
        if (e_valid) check({tag, " data"}, 32'(data), 32'((sz != 0) ? q[0] : prev_i_data));
        acc = prev_i_valid && e_ready;
        pop = e_valid && next_i_ready;
        if (flush) begin
            q.delete();
        end else if (sz == 0) begin
            if (acc && !next_i_ready) q.push_back(prev_i_data);
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(prev_i_data);
        end
        rdy = flush ? 1'b1 : (q.size() < depth);
    endtask

    // Drives one cycle's inputs, checks all instances at the falling edge,
    // advances the models and returns just after the next rising edge.
    task automatic cycle(input bit f, input bit v, input logic [7:0] d, input bit nr);
        flush        = f;
        prev_i_valid = v;
        prev_i_data  = d;
        next_i_ready = nr;
        @(negedge clk);
        model_step("A", 2, 1'b1, q_a, rdy_a, a_ready, a_valid, a_data, {1'b0, a_count}, acc_a);
        model_step("B", 4, 1'b1, q_b, rdy_b, b_ready, b_valid, b_data, b_count,         acc_b);
        model_step("C", 3, 1'b0, q_c, rdy_c, c_ready, c_valid, c_data, {1'b0, c_count}, acc_c);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        q_a.delete(); q_b.delete(); q_c.delete();
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    endtask

    // Upstream source that holds its beat until instance B accepts it.
    task automatic run_source(input int cycles, input int nr_pct, input int flush_pct,
                              input bit first_val, input logic [7:0] first_d);
        bit         v = first_val;
        logic [7:0] d = first_d;
        bit         f, nr;
        for (int i = 0; i < cycles; i++) begin
            nr = ($urandom_range(99) < nr_pct);
            f  = ($urandom_range(99) < flush_pct);
            cycle(f, v, d, nr);
            if (acc_b || !v || f) begin
                v = $urandom_range(1);
                d = 8'($urandom);
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b1; flush = 1'b0; prev_i_data = '0; prev_i_valid = 1'b0; next_i_ready = 1'b0;
        clear_models();

        // Reset state while reset is held across edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst a_count", 32'(a_count), 0);
        check("rst b_count", 32'(b_count), 0);
        check("rst c_count", 32'(c_count), 0);
        check("rst a_valid", 32'(a_valid), 0);
        check("rst c_valid", 32'(c_valid), 0);
        check("rst a_ready", 32'(a_ready), 0);
        check("rst b_ready", 32'(b_ready), 0);

        // Release between edges: comb ready rises at once, registered stays low.
        #2 reset = 1'b0;
        #1;
        check("rel c_ready", 32'(c_ready), 1);
        check("rel b_ready", 32'(b_ready), 0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Bypass stream with downstream always ready.
        for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 8'(i), 1'b1);

        // Fill and stall: B fills with A0..A3, then drains A0..A5 in order.
        d = 8'hA0;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, d, 1'b0);
            if (acc_b) d++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, d <= 8'hA5, d, 1'b1);
            if (acc_b) d++;
        end

        // Simultaneous push/pop at full on C (comb), crossing pointer wrap.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Flush with upstream valid after loading three entries.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'h5F, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomised traffic with stalls and occasional flush.
        run_source(600, 60, 2, 1'b1, 8'h77);
        repeat (6) cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset between edges with two entries stored.
        cycle(1'b0, 1'b1, 8'hC0, 1'b0);
        cycle(1'b0, 1'b1, 8'hC1, 1'b0);
        check("pre-rst b_count", 32'(b_count), 2);
        #1 reset = 1'b1;
        #1;
        check("async b_count", 32'(b_count), 0);
        check("async a_count", 32'(a_count), 0);
        check("async c_count", 32'(c_count), 0);
        check("async b_valid", 32'(b_valid), 0);
        check("async a_valid", 32'(a_valid), 0);
        check("async b_ready", 32'(b_ready), 0);
        clear_models();
        prev_i_valid = 1'b0;
        #1 reset = 1'b0;
        run_source(200, 70, 0, 1'b1, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
